i2c_mem_port: RTL
=================

// Module: i2c_mem_port
// PURPOSE
//  Parametrised byte-level memory bridge for the I2C subordinate, clocked on the system clock.
//  Sits between the I2C byte engine (START/STOP detect, shift, ACK) and an internal RAM of DEPTH bytes.
//  Multi-byte pointer phase, burst write/read with auto-increment and wrap, NACK on out-of-range pointer.
//  Adds optional write protection.
// PARAMETERS
//  DEPTH       128                      memory size in bytes, any value >= 2 (not required to be a power of 2)
//  ADDR_W      $clog2(DEPTH)            pointer width (derived)
//  ADDR_BYTES  (ADDR_W+7)/8             pointer bytes sent by master, MSB byte first (derived)
// PORTS
//  clk           in   1       system clock; single clock domain
//  rst           in   1       synchronous, active-high reset
//  start_evt     in   1       1-cycle pulse: START/repeated START with own address matched
//  rw            in   1       sampled with start_evt; 1 = master read, 0 = master write
//  stop_evt      in   1       1-cycle pulse: STOP detected
//  rx_valid      in   1       1-cycle pulse: rx_data holds a received byte
//  rx_data       in   8       received byte
//  rx_ack_valid  out  1       1-cycle pulse, exactly 1 clk after rx_valid
//  rx_ack        out  1       1 = ACK, 0 = NACK; qualified by rx_ack_valid
//  tx_req        in   1       1-cycle pulse: engine needs the next read byte
//  tx_valid      out  1       1-cycle pulse, exactly 1 clk after tx_req
//  tx_data       out  8       byte to transmit; held until the next tx_valid
//  ptr           out  ADDR_W  current memory pointer
//  busy          out  1       1 whenever state != IDLE
//  wp            in   1       write-protect request (only present with I2C_MEM_WP_EN)
// BEHAVIOUR
//  Reset values: rx_ack_valid=0, rx_ack=0, tx_valid=0, tx_data=0, ptr=0, busy=0, state=IDLE.
//  RAM contents are not cleared by rst.
//  FSM states: IDLE, PTR, WRITE, READ, DISCARD.
//  - start_evt & !rw: go to PTR; clear byte_cnt.
//  - start_evt & rw: go to READ; ptr is kept, so a repeated START after the pointer phase gives random read.
//  - stop_evt: go to IDLE from any state.
//  PTR: each rx byte shifts into the pointer shadow (MSB byte first) and increments byte_cnt.
//  - On byte ADDR_BYTES, if shadow < DEPTH: load ptr, ACK, go to WRITE.
//  - Otherwise: NACK, ptr unchanged, go to DISCARD.
//  - Bits of the shadow above ADDR_W must be 0; a set upper bit counts as out of range.
//  WRITE: rx byte -> mem[ptr] <= rx_data, ACK, ptr <= next(ptr).
//  READ: tx_req -> tx_data <= mem[ptr] (1-cycle synchronous read), tx_valid=1 next clk, ptr <= next(ptr).
//  - The master's ACK/NACK of read bytes is not tracked; the engine stops issuing tx_req after a NACK.
//  DISCARD: every rx byte gets a NACK and the RAM is not written. tx_req returns tx_data=8'hFF.
//  next(p) = (p == DEPTH-1) ? 0 : p+1; wraps at DEPTH-1 -> 0.
//  rx_valid or tx_req in IDLE: rx gets a NACK; tx returns 8'hFF; ptr unchanged.
//  Simultaneous events:
//  - start_evt + rx_valid same clk: start_evt wins; the byte is dropped with no rx_ack_valid.
//  - stop_evt + rx_valid same clk: the byte is processed first (write/ack), then IDLE.
//  - stop_evt + tx_req same clk: tx completes, then IDLE.
//  - rx_valid + tx_req same clk: protocol error; rx has priority and tx_valid returns 8'hFF.
//  rst mid-transfer: state returns to IDLE on the next edge; pending ack/tx pulses are cancelled.
// CONFIGURATION
//  I2C_MEM_WP_EN defined: wp port present.
//  - In WRITE with wp=1 (sampled on the rx_valid clk): RAM is not written, NACK returned, ptr still increments.
//  - Pointer phase and reads are unaffected by wp.
//  I2C_MEM_WP_EN undefined: no wp port; all in-range writes are ACKed and committed.
// STRUCTURE
//  Package i2c_mem_pkg: state_t enum {IDLE,PTR,WRITE,READ,DISCARD}, ACK=1'b1/NACK=1'b0, IDLE_DATA=8'hFF.
//  Sub-module i2c_mem_ptr: pointer shadow, byte_cnt, range check, next() wrap logic.
//  RAM is an inferred array inside i2c_mem_port.
// TESTING
//  1 Write burst: start_evt rw=0; rx 8'h10, 8'hA1, 8'hB2, 8'hC3 -> four ACKs; mem[0x10..0x12]=A1,B2,C3; ptr=0x13.
//  2 Random read: after test 1, rx 8'h11, then start_evt rw=1, two tx_req -> tx_data B2 then C3, each 1 clk after tx_req.
//  3 Wrap: DEPTH=128, ptr 8'h7F, write 8'h55, 8'h66 -> mem[0x7F]=55, mem[0x00]=66, ptr=0x01.
//  4 Out of range: DEPTH=100, pointer 8'h64 -> NACK; following rx 8'h77 NACKed; RAM unchanged; ptr unchanged.
//  5 DEPTH=1024 (ADDR_BYTES=2): rx 8'h03, 8'hFF, 8'h5A -> mem[0x3FF]=5A, ptr wraps to 0.
//  6 Reset mid-write (rst on the rx_valid clk of byte 3) -> no rx_ack_valid, busy=0, ptr=0; RAM keeps earlier bytes.
//  7 With I2C_MEM_WP_EN, wp=1: write 8'h20, 8'hEE -> pointer ACK, data NACK; mem[0x20] unchanged; ptr=0x21.

Source files
------------

// File: rtl/i2c_mem_pkg.sv
// Shared types and constants for the I2C memory bridge (i2c_mem_ptr, i2c_mem_port).
package i2c_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PTR,
      WRITE,
      READ,
      DISCARD
   } state_t;

   localparam logic       ACK       = 1'b1;
   localparam logic       NACK      = 1'b0;
   localparam logic [7:0] IDLE_DATA = 8'hFF;

endpackage

// File: rtl/i2c_mem_ptr.sv
// Memory pointer for the I2C bridge: pointer shadow (MSB byte first), byte counter,
// range check of the assembled pointer and wrap-at-DEPTH increment.
module i2c_mem_ptr #(
   parameter  int DEPTH      = 128,
   localparam int ADDR_W     = $clog2(DEPTH),
   localparam int ADDR_BYTES = (ADDR_W + 7) / 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_shift,
   input  logic [7:0]        i_rx_data,
   input  logic              i_load,
   input  logic              i_adv,
   output logic [ADDR_W-1:0] o_ptr,
   output logic              o_last,
   output logic              o_in_range
);

   localparam int                SH_W      = 8 * ADDR_BYTES;
   localparam int                CNT_W     = $clog2(ADDR_BYTES + 1);
   localparam logic [SH_W:0]     DEPTH_V   = (SH_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [SH_W-1:0]   r_shadow;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_ptr;
   logic [SH_W-1:0]   w_shadow_nxt;
   logic [ADDR_W-1:0] w_ptr_inc;

   // Range check looks at the shadow including the byte arriving this cycle,
   // so any set bit above ADDR_W also fails the compare.
   assign w_shadow_nxt = (r_shadow << 8) | SH_W'(i_rx_data);
   assign o_in_range   = {1'b0, w_shadow_nxt} < DEPTH_V;
   assign o_last       = (r_cnt == CNT_W'(ADDR_BYTES - 1));
   assign w_ptr_inc    = (r_ptr == LAST_ADDR) ? '0 : r_ptr + ADDR_W'(1);
   assign o_ptr        = r_ptr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shadow <= '0;
         r_cnt    <= '0;
         r_ptr    <= '0;
      end else begin
         if (i_clr) begin
            r_shadow <= '0;
            r_cnt    <= '0;
         end else if (i_shift) begin
            r_shadow <= w_shadow_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
         end
         if (i_load) begin
            r_ptr <= w_shadow_nxt[ADDR_W-1:0];
         end else if (i_adv) begin
            r_ptr <= w_ptr_inc;
         end
      end
   end

endmodule

// File: rtl/i2c_mem_port.sv
// Byte-level RAM bridge behind an I2C subordinate byte engine.
// Optional write protection (wp port) is built when I2C_MEM_WP_EN is defined.
module i2c_mem_port
   import i2c_mem_pkg::*;
#(
   parameter  int DEPTH      = 128,
   localparam int ADDR_W     = $clog2(DEPTH),
   localparam int ADDR_BYTES = (ADDR_W + 7) / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_evt,
   input  logic              rw,
   input  logic              stop_evt,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ack_valid,
   output logic              rx_ack,
   input  logic              tx_req,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   output logic [ADDR_W-1:0] ptr,
   output logic              busy,
`ifdef I2C_MEM_WP_EN
   input  logic              wp,
`endif
   output state_t            dbg_state
);

   // Handshake: every input event is a 1-cycle pulse with no back-pressure; each
   // rx_valid yields exactly one rx_ack_valid and each tx_req exactly one tx_valid,
   // both registered one clock later, unless start_evt or rst swallow the event.

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_mem [DEPTH];
   logic              r_ack_v;
   logic              r_ack;
   logic              r_tx_v;
   logic [7:0]        r_tx_data;
   logic [ADDR_W-1:0] w_ptr;
   logic              w_ack_v;
   logic              w_ack;
   logic              w_tx_v;
   logic              w_tx_rd;
   logic              w_we;
   logic              w_clr;
   logic              w_shift;
   logic              w_load;
   logic              w_adv;
   logic              w_last;
   logic              w_in_range;
   logic              w_wp;

`ifdef I2C_MEM_WP_EN
   assign w_wp = wp;
`else
   assign w_wp = 1'b0;
`endif

   i2c_mem_ptr #(
      .DEPTH (DEPTH)
   ) u_ptr (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_clr      (w_clr),
      .i_shift    (w_shift),
      .i_rx_data  (rx_data),
      .i_load     (w_load),
      .i_adv      (w_adv),
      .o_ptr      (w_ptr),
      .o_last     (w_last),
      .o_in_range (w_in_range)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ack_v     = 1'b0;
      w_ack       = NACK;
      w_tx_v      = 1'b0;
      w_tx_rd     = 1'b0;
      w_we        = 1'b0;
      w_clr       = 1'b0;
      w_shift     = 1'b0;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      if (start_evt) begin
         // START takes the whole cycle: a coincident byte or tx request is dropped.
         w_clr       = !rw;
         w_state_nxt = rw ? READ : PTR;
      end else begin
         if (rx_valid) begin
            w_ack_v = 1'b1;
            case (r_state)
               PTR: begin
                  w_shift = 1'b1;
                  if (!w_last) begin
                     w_ack = ACK;
                  end else if (w_in_range) begin
                     w_load      = 1'b1;
                     w_ack       = ACK;
                     w_state_nxt = WRITE;
                  end else begin
                     w_state_nxt = DISCARD;
                  end
               end
               WRITE: begin
                  w_adv = 1'b1;
                  if (!w_wp) begin
                     w_we  = 1'b1;
                     w_ack = ACK;
                  end
               end
               default: ;
            endcase
         end
         // A tx request colliding with rx is a protocol error and gets filler data.
         if (tx_req) begin
            w_tx_v = 1'b1;
            if (!rx_valid && r_state == READ) begin
               w_tx_rd = 1'b1;
               w_adv   = 1'b1;
            end
         end
         if (stop_evt) begin
            w_state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ack_v   <= 1'b0;
         r_ack     <= 1'b0;
         r_tx_v    <= 1'b0;
         r_tx_data <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         r_ack_v <= w_ack_v;
         r_ack   <= w_ack;
         r_tx_v  <= w_tx_v;
         if (w_tx_v) begin
            r_tx_data <= w_tx_rd ? r_mem[w_ptr] : IDLE_DATA;
         end
      end
   end

   // RAM contents survive rst; only the write itself is blocked during reset.
   always_ff @(posedge clk) begin
      if (w_we && !rst) begin
         r_mem[w_ptr] <= rx_data;
      end
   end

   assign rx_ack_valid = r_ack_v;
   assign rx_ack       = r_ack;
   assign tx_valid     = r_tx_v;
   assign tx_data      = r_tx_data;
   assign ptr          = w_ptr;
   assign busy         = (r_state != IDLE);
   assign dbg_state    = r_state;

endmodule
